axi_sram_responder: RTL and testbench

AXI3 slave that answers the CPU's burst requests from an on-chip synchronous SRAM. It sits on the far side of one of the CPU's AXI master ports (icache, dcache or uncached) in simulation benches and small SoC builds. It is a single-outstanding-transaction responder with read/write round-robin arbitration, INCR/FIXED/WRAP burst addressing and byte-strobed writes.

---
 rtl/axi_pkg.sv | 19 +
 rtl/axi_burst_addr.sv | 50 +++++
 rtl/axi_sram_responder.sv | 198 +++++++++++++++++++
 tb/tb_axi_sram_responder.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/axi_pkg.sv
// Shared AXI3 definitions for the SRAM responder: burst and response codes, FSM state type.
package axi_pkg;

  typedef enum logic [1:0] {
    StIdle,
    StRead,
    StWrite,
    StWresp
  } state_e;

  localparam logic [1:0] BurstFixed = 2'b00;
  localparam logic [1:0] BurstIncr  = 2'b01;
  localparam logic [1:0] BurstWrap  = 2'b10;
  localparam logic [1:0] BurstRsvd  = 2'b11;

  localparam logic [1:0] RespOkay   = 2'b00;
  localparam logic [1:0] RespSlverr = 2'b10;

endpackage

// File: rtl/axi_burst_addr.sv
// Next word address for FIXED/INCR/WRAP bursts, shared by read and write paths.
// AXI_SRAM_WRAP_EN enables true WRAP addressing; otherwise WRAP behaves as INCR.
module axi_burst_addr
  import axi_pkg::*;
#(
  parameter int unsigned MEM_AW = 14
) (
  input  logic [MEM_AW-1:0] cur_addr_i,
  input  logic [3:0]        len_i,
  input  logic [1:0]        burst_i,
  output logic [MEM_AW-1:0] next_addr_o,
  output logic              err_o
);

  logic [MEM_AW-1:0] incr_addr;
  assign incr_addr = cur_addr_i + MEM_AW'(1);

`ifdef AXI_SRAM_WRAP_EN
  logic [MEM_AW-1:0] wrap_mask;
  logic [MEM_AW-1:0] wrap_addr;
  logic              len_legal;
  assign wrap_mask = MEM_AW'(len_i);
  // Low bits step within the aligned window, high bits stay put.
  assign wrap_addr = (cur_addr_i & ~wrap_mask) | (incr_addr & wrap_mask);
  assign len_legal = (len_i == 4'd1) || (len_i == 4'd3) || (len_i == 4'd7) || (len_i == 4'd15);
`else
  logic unused_len;
  assign unused_len = ^len_i;
`endif

  always_comb begin
    next_addr_o = incr_addr;
    err_o       = 1'b0;
    unique case (burst_i)
      BurstFixed: next_addr_o = cur_addr_i;
      BurstIncr:  next_addr_o = incr_addr;
      BurstWrap: begin
`ifdef AXI_SRAM_WRAP_EN
        if (len_legal) begin
          next_addr_o = wrap_addr;
        end else begin
          err_o = 1'b1;
        end
`endif
      end
      default:    err_o = 1'b1;
    endcase
  end

endmodule

// File: rtl/axi_sram_responder.sv
// Single-outstanding AXI3 slave serving read/write bursts from a 2^MEM_AW x 32 synchronous SRAM.
// AXI_SRAM_WRAP_EN (see axi_burst_addr) selects real WRAP addressing.
module axi_sram_responder
  import axi_pkg::*;
#(
  parameter int unsigned ID_WIDTH = 4,
  parameter int unsigned MEM_AW   = 14
) (
  input  logic                aclk,
  input  logic                reset_n,
  input  logic [ID_WIDTH-1:0] arid,
  input  logic [31:0]         araddr,
  input  logic [3:0]          arlen,
  input  logic [1:0]          arburst,
  input  logic                arvalid,
  output logic                arready,
  output logic [ID_WIDTH-1:0] rid,
  output logic [31:0]         rdata,
  output logic [1:0]          rresp,
  output logic                rlast,
  output logic                rvalid,
  input  logic                rready,
  input  logic [ID_WIDTH-1:0] awid,
  input  logic [31:0]         awaddr,
  input  logic [3:0]          awlen,
  input  logic [1:0]          awburst,
  input  logic                awvalid,
  output logic                awready,
  input  logic [31:0]         wdata,
  input  logic [3:0]          wstrb,
  input  logic                wlast,
  input  logic                wvalid,
  output logic                wready,
  output logic [ID_WIDTH-1:0] bid,
  output logic [1:0]          bresp,
  output logic                bvalid,
  input  logic                bready
);

  localparam int unsigned Words = 2 ** MEM_AW;

  state_e              state_q, state_d;
  logic                last_rd_q, last_rd_d;
  logic [ID_WIDTH-1:0] id_q, id_d;
  logic [MEM_AW-1:0]   addr_q, addr_d;
  logic [3:0]          len_q, len_d;
  logic [1:0]          burst_q, burst_d;
  logic [3:0]          cnt_q, cnt_d;
  logic                werr_q, werr_d;
  logic                rvalid_q, rvalid_d;

  logic [MEM_AW-1:0]   next_addr;
  logic                burst_err;
  logic [MEM_AW-1:0]   mem_raddr;
  logic                mem_we;
  logic [31:0]         mem_rdata_q;
  logic [31:0]         sram_q [Words];
  logic                grant_rd;
  logic                beat_last;

  logic unused_addr;
  assign unused_addr = ^{araddr[31:MEM_AW+2], araddr[1:0], awaddr[31:MEM_AW+2], awaddr[1:0]};

  axi_burst_addr #(
    .MEM_AW (MEM_AW)
  ) u_burst_addr (
    .cur_addr_i  (addr_q),
    .len_i       (len_q),
    .burst_i     (burst_q),
    .next_addr_o (next_addr),
    .err_o       (burst_err)
  );

  assign grant_rd  = arvalid && (!awvalid || !last_rd_q);
  assign beat_last = (cnt_q == len_q);

  always_comb begin
    state_d   = state_q;
    last_rd_d = last_rd_q;
    id_d      = id_q;
    addr_d    = addr_q;
    len_d     = len_q;
    burst_d   = burst_q;
    cnt_d     = cnt_q;
    werr_d    = werr_q;
    rvalid_d  = rvalid_q;
    arready   = 1'b0;
    awready   = 1'b0;
    wready    = 1'b0;
    mem_we    = 1'b0;
    unique case (state_q)
      StIdle: begin
        if (grant_rd) begin
          arready  = 1'b1;
          state_d  = StRead;
          id_d     = arid;
          addr_d   = araddr[MEM_AW+1:2];
          len_d    = arlen;
          burst_d  = arburst;
          cnt_d    = 4'd0;
          rvalid_d = 1'b0;
        end else if (awvalid) begin
          awready = 1'b1;
          state_d = StWrite;
          id_d    = awid;
          addr_d  = awaddr[MEM_AW+1:2];
          len_d   = awlen;
          burst_d = awburst;
          cnt_d   = 4'd0;
          werr_d  = 1'b0;
        end
      end
      StRead: begin
        // First cycle in READ only primes the SRAM output register.
        if (!rvalid_q) begin
          rvalid_d = 1'b1;
        end else if (rready) begin
          cnt_d  = cnt_q + 4'd1;
          addr_d = next_addr;
          if (beat_last) begin
            state_d   = StIdle;
            rvalid_d  = 1'b0;
            last_rd_d = 1'b1;
          end
        end
      end
      StWrite: begin
        wready = 1'b1;
        if (wvalid) begin
          mem_we = 1'b1;
          cnt_d  = cnt_q + 4'd1;
          addr_d = next_addr;
          if (wlast != beat_last) begin
            werr_d = 1'b1;
          end
          if (beat_last) begin
            state_d = StWresp;
          end
        end
      end
      StWresp: begin
        if (bready) begin
          state_d   = StIdle;
          last_rd_d = 1'b0;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge aclk or negedge reset_n) begin
    if (!reset_n) begin
      state_q   <= StIdle;
      last_rd_q <= 1'b0;
      id_q      <= '0;
      addr_q    <= '0;
      len_q     <= '0;
      burst_q   <= '0;
      cnt_q     <= '0;
      werr_q    <= 1'b0;
      rvalid_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      last_rd_q <= last_rd_d;
      id_q      <= id_d;
      addr_q    <= addr_d;
      len_q     <= len_d;
      burst_q   <= burst_d;
      cnt_q     <= cnt_d;
      werr_q    <= werr_d;
      rvalid_q  <= rvalid_d;
    end
  end

  // Look ahead on a handshake so the next beat is ready; otherwise re-read to hold data.
  assign mem_raddr = (state_q == StRead && rvalid_q && rready) ? next_addr : addr_q;

  always_ff @(posedge aclk) begin
    if (mem_we) begin
      for (int i = 0; i < 4; i++) begin
        if (wstrb[i]) begin
          sram_q[addr_q][8*i +: 8] <= wdata[8*i +: 8];
        end
      end
    end
    mem_rdata_q <= sram_q[mem_raddr];
  end

  assign rvalid = rvalid_q;
  assign rdata  = rvalid_q ? mem_rdata_q : 32'd0;
  assign rlast  = rvalid_q && beat_last;
  assign rresp  = (rvalid_q && burst_err) ? RespSlverr : RespOkay;
  assign rid    = id_q;
  assign bvalid = (state_q == StWresp);
  assign bresp  = (bvalid && (werr_q || burst_err)) ? RespSlverr : RespOkay;
  assign bid    = id_q;

endmodule

// File: tb/tb_axi_sram_responder.sv
// Directed self-checking bench for axi_sram_responder; WRAP expectations follow AXI_SRAM_WRAP_EN.
module tb_axi_sram_responder;
  import axi_pkg::*;

  logic        aclk;
  logic        reset_n;
  logic [3:0]  arid, rid, awid, bid;
  logic [31:0] araddr, rdata, awaddr, wdata;
  logic [3:0]  arlen, awlen, wstrb;
  logic [1:0]  arburst, rresp, awburst, bresp;
  logic        arvalid, arready, rlast, rvalid, rready;
  logic        awvalid, awready, wlast, wvalid, wready, bvalid, bready;

  int checks = 0;
  int errors = 0;

  logic [31:0] rd_q[$];
  logic        rl_q[$];
  logic [1:0]  rr_q[$];
  logic [31:0] wr_data[$];
  int          first_rv;
  logic [1:0]  b_resp;
  logic [3:0]  b_id;

  axi_sram_responder #(
    .ID_WIDTH (4),
    .MEM_AW   (14)
  ) dut (
    .aclk    (aclk),
    .reset_n (reset_n),
    .arid    (arid),
    .araddr  (araddr),
    .arlen   (arlen),
    .arburst (arburst),
    .arvalid (arvalid),
    .arready (arready),
    .rid     (rid),
    .rdata   (rdata),
    .rresp   (rresp),
    .rlast   (rlast),
    .rvalid  (rvalid),
    .rready  (rready),
    .awid    (awid),
    .awaddr  (awaddr),
    .awlen   (awlen),
    .awburst (awburst),
    .awvalid (awvalid),
    .awready (awready),
    .wdata   (wdata),
    .wstrb   (wstrb),
    .wlast   (wlast),
    .wvalid  (wvalid),
    .wready  (wready),
    .bid     (bid),
    .bresp   (bresp),
    .bvalid  (bvalid),
    .bready  (bready)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic do_write(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                          input logic [1:0] burst, input logic [3:0] strb, input int last_at);
    bit ok;
    int nacc;
    awid = id; awaddr = addr; awlen = len; awburst = burst; awvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge aclk); ok = awready; @(posedge aclk); #1;
    end
    awvalid = 1'b0;
    check("aw_hs", 32'(ok), 32'd1);
    nacc = 0;
    for (int i = 0; i <= int'(len); i++) begin
      wvalid = 1'b1; wdata = wr_data[i]; wstrb = strb; wlast = (i == last_at);
      ok = 1'b0;
      for (int t = 0; t < 20 && !ok; t++) begin
        @(negedge aclk); ok = wready; @(posedge aclk); #1;
      end
      nacc += int'(ok);
    end
    wvalid = 1'b0; wlast = 1'b0;
    check("w_beats", 32'(nacc), 32'(len) + 32'd1);
    check("b_timing", 32'(bvalid), 32'd1);
    b_resp = bresp; b_id = bid;
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
  endtask

  task automatic do_read(input logic [3:0] id, input logic [31:0] addr, input logic [3:0] len,
                         input logic [1:0] burst, input bit toggle);
    bit ok;
    bit stalled;
    int n;
    logic [31:0] held;
    rd_q.delete(); rl_q.delete(); rr_q.delete();
    arid = id; araddr = addr; arlen = len; arburst = burst; arvalid = 1'b1;
    ok = 1'b0;
    for (int t = 0; t < 20 && !ok; t++) begin
      @(negedge aclk); ok = arready; @(posedge aclk); #1;
    end
    arvalid = 1'b0;
    check("ar_hs", 32'(ok), 32'd1);
    n = 0; stalled = 1'b0; first_rv = -1; held = '0;
    for (int t = 0; t < 100 && n <= int'(len); t++) begin
      rready = toggle ? (t % 2 == 0) : 1'b1;
      @(negedge aclk);
      if (rvalid && first_rv < 0) first_rv = t;
      if (stalled) check("r_stable", rdata, held);
      stalled = 1'b0;
      if (rvalid && rready) begin
        rd_q.push_back(rdata); rl_q.push_back(rlast); rr_q.push_back(rresp);
        n++;
      end else if (rvalid) begin
        stalled = 1'b1; held = rdata;
      end
      @(posedge aclk); #1;
    end
    rready = 1'b0;
    check("r_beats", 32'(n), 32'(len) + 32'd1);
  endtask

  initial begin
    logic [31:0] wrap_exp[4];
    reset_n = 1'b0;
    arid = '0; araddr = '0; arlen = '0; arburst = '0; arvalid = 1'b0; rready = 1'b0;
    awid = '0; awaddr = '0; awlen = '0; awburst = '0; awvalid = 1'b0;
    wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
    repeat (3) @(posedge aclk);
    #1;
    check("rst_rvalid", 32'(rvalid), 32'd0);
    check("rst_rdata", rdata, 32'd0);
    check("rst_bvalid", 32'(bvalid), 32'd0);
    check("rst_wready", 32'(wready), 32'd0);
    reset_n = 1'b1;
    @(posedge aclk); #1;

    // INCR write then read back, with IDs echoed
    wr_data = '{32'd1, 32'd2, 32'd3, 32'd4};
    do_write(4'd9, 32'h100, 4'd3, BurstIncr, 4'hF, 3);
    check("wr1_bresp", 32'(b_resp), 32'd0);
    check("wr1_bid", 32'(b_id), 32'd9);
    do_read(4'd5, 32'h100, 4'd3, BurstIncr, 1'b0);
    check("rd1_latency", 32'(first_rv), 32'd1);
    check("rd1_rid", 32'(rid), 32'd5);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      check("rd1_data", rd_q[i], 32'(i + 1));
      check("rd1_rlast", 32'(rl_q[i]), 32'(i == 3));
      check("rd1_rresp", 32'(rr_q[i]), 32'd0);
    end

    // Byte strobes
    wr_data = '{32'hFFFF_FFFF};
    do_write(4'd1, 32'h40, 4'd0, BurstIncr, 4'hF, 0);
    wr_data = '{32'h1122_3344};
    do_write(4'd1, 32'h40, 4'd0, BurstIncr, 4'b0101, 0);
    do_read(4'd1, 32'h40, 4'd0, BurstIncr, 1'b0);
    if (rd_q.size() > 0) check("strb_data", rd_q[0], 32'hFF22_FF44);

    // WRAP: words at 0x10..0x2C hold their own byte address
    wr_data = '{32'h10, 32'h14, 32'h18, 32'h1C, 32'h20, 32'h24, 32'h28, 32'h2C};
    do_write(4'd2, 32'h10, 4'd7, BurstIncr, 4'hF, 7);
    do_read(4'd2, 32'h1C, 4'd3, BurstWrap, 1'b0);
`ifdef AXI_SRAM_WRAP_EN
    wrap_exp = '{32'h1C, 32'h10, 32'h14, 32'h18};
`else
    wrap_exp = '{32'h1C, 32'h20, 32'h24, 32'h28};
`endif
    for (int i = 0; i < 4 && i < rd_q.size(); i++) begin
      check("wrap_data", rd_q[i], wrap_exp[i]);
      check("wrap_rresp", 32'(rr_q[i]), 32'd0);
    end

    // FIXED repeats one word; reserved burst reads as INCR with SLVERR
    do_read(4'd3, 32'h104, 4'd2, BurstFixed, 1'b0);
    for (int i = 0; i < 3 && i < rd_q.size(); i++) check("fixed_data", rd_q[i], 32'd2);
    do_read(4'd4, 32'h100, 4'd1, BurstRsvd, 1'b0);
    for (int i = 0; i < 2 && i < rd_q.size(); i++) begin
      check("rsvd_data", rd_q[i], 32'(i + 1));
      check("rsvd_rresp", 32'(rr_q[i]), 32'd2);
    end

    // Backpressure: rready 1,0,1,0...
    do_read(4'd6, 32'h100, 4'd3, BurstIncr, 1'b1);
    for (int i = 0; i < 4 && i < rd_q.size(); i++) check("bp_data", rd_q[i], 32'(i + 1));

    // Early wlast on beat 2: all four beats still taken, SLVERR
    wr_data = '{32'hA0, 32'hA1, 32'hA2, 32'hA3};
    do_write(4'd7, 32'h300, 4'd3, BurstIncr, 4'hF, 1);
    check("wlast_bresp", 32'(b_resp), 32'd2);

    // Arbitration from reset: read, write, read
    reset_n = 1'b0; @(posedge aclk); #1; reset_n = 1'b1; @(posedge aclk); #1;
    arid = 4'd6; araddr = 32'h200; arlen = 4'd0; arburst = BurstIncr; arvalid = 1'b1;
    awid = 4'd7; awaddr = 32'h200; awlen = 4'd0; awburst = BurstIncr; awvalid = 1'b1;
    @(negedge aclk);
    check("arb1_arready", 32'(arready), 32'd1);
    check("arb1_awready", 32'(awready), 32'd0);
    @(posedge aclk); #1; arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    check("arb1_rvalid", 32'(rvalid), 32'd1);
    @(posedge aclk); #1; rready = 1'b0;
    arid = 4'd8; arvalid = 1'b1;
    @(negedge aclk);
    check("arb2_awready", 32'(awready), 32'd1);
    check("arb2_arready", 32'(arready), 32'd0);
    @(posedge aclk); #1;
    awaddr = 32'h204;
    wvalid = 1'b1; wdata = 32'hCAFE_F00D; wstrb = 4'hF; wlast = 1'b1;
    @(negedge aclk);
    check("arb2_wready", 32'(wready), 32'd1);
    @(posedge aclk); #1; wvalid = 1'b0; wlast = 1'b0;
    check("arb2_bvalid", 32'(bvalid), 32'd1);
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;
    @(negedge aclk);
    check("arb3_arready", 32'(arready), 32'd1);
    check("arb3_awready", 32'(awready), 32'd0);
    @(posedge aclk); #1; arvalid = 1'b0; rready = 1'b1;
    @(posedge aclk); #1;
    check("arb3_rdata", rdata, 32'hCAFE_F00D);
    check("arb3_rid", 32'(rid), 32'd8);
    @(posedge aclk); #1; rready = 1'b0;
    @(negedge aclk);
    check("arb4_awready", 32'(awready), 32'd1);
    @(posedge aclk); #1; awvalid = 1'b0;
    wvalid = 1'b1; wdata = 32'h5555_5555; wstrb = 4'hF; wlast = 1'b1;
    @(posedge aclk); #1; wvalid = 1'b0; wlast = 1'b0;
    bready = 1'b1; @(posedge aclk); #1; bready = 1'b0;

    // Reset during beat 2 of a read
    arid = 4'd2; araddr = 32'h100; arlen = 4'd3; arburst = BurstIncr; arvalid = 1'b1;
    rready = 1'b1;
    @(negedge aclk);
    check("rst_ar", 32'(arready), 32'd1);
    @(posedge aclk); #1; arvalid = 1'b0;
    @(posedge aclk); #1;
    check("rst_beat1", rdata, 32'd1);
    @(posedge aclk); #1;
    check("rst_beat2", rdata, 32'd2);
    reset_n = 1'b0; #1;
    check("rst_mid_rvalid", 32'(rvalid), 32'd0);
    check("rst_mid_rdata", rdata, 32'd0);
    rready = 1'b0;
    @(posedge aclk); #1; reset_n = 1'b1;
    @(posedge aclk); #1;
    do_read(4'd3, 32'h100, 4'd1, BurstIncr, 1'b0);
    for (int i = 0; i < 2 && i < rd_q.size(); i++) check("post_rst_data", rd_q[i], 32'(i + 1));
    check("post_rst_rid", 32'(rid), 32'd3);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
